// File: rtl/adunare_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor. Each 4-bit group resolves in its own stage
// from the registered carry of the group below; the whole pipeline stalls as one.
module adunare_cla_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / 4;

  // Returns {c4, c3, s[3:0]}; every carry is a flat sum of products, no ripple.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], c[3], p ^ c[3:0]};
  endfunction

  // Sum bits enter at the top and shift down one group per stage, so they deskew themselves.
  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] prev, input logic [3:0] sg);
    logic [WIDTH-1:0] t;
    t = prev >> 3'd4;
    t[WIDTH-1 -: 4] = sg;
    return t;
  endfunction

  logic [WIDTH-1:0]  opx_q [STAGES];
  logic [WIDTH-1:0]  opx_d [STAGES];
  logic [WIDTH-1:0]  opy_q [STAGES];
  logic [WIDTH-1:0]  opy_d [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  yy;
  logic              c0;
  logic [5:0]        grp;
  logic              stall;

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Stage k works on the low group of its operand registers, which are shifted down by one group per stage.
  always_comb begin
    yy       = sub ? ~y : y;
    c0       = sub ? ~cin : cin;
    grp      = cla4(x[3:0], yy[3:0], c0);
    opx_d[0] = x >> 3'd4;
    opy_d[0] = yy >> 3'd4;
    s_d[0]   = place({WIDTH{1'b0}}, grp[3:0]);
    c_d      = {STAGES{1'b0}};
    v_d      = {STAGES{1'b0}};
    c_d[0]   = grp[5];
    v_d[0]   = in_valid & in_ready;
    ovf_d    = grp[4] ^ grp[5];
    for (int k = 1; k < STAGES; k++) begin
      grp      = cla4(opx_q[k-1][3:0], opy_q[k-1][3:0], c_q[k-1]);
      opx_d[k] = opx_q[k-1] >> 3'd4;
      opy_d[k] = opy_q[k-1] >> 3'd4;
      s_d[k]   = place(s_q[k-1], grp[3:0]);
      c_d[k]   = grp[5];
      v_d[k]   = v_q[k-1];
      ovf_d    = grp[4] ^ grp[5];
    end
  end

  // Pipeline registers: synchronous reset, otherwise advance as a whole unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= {STAGES{1'b0}};
      c_q   <= {STAGES{1'b0}};
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opx_q[k] <= {WIDTH{1'b0}};
        opy_q[k] <= {WIDTH{1'b0}};
        s_q[k]   <= {WIDTH{1'b0}};
      end
    end else if (!stall) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        opx_q[k] <= opx_d[k];
        opy_q[k] <= opy_d[k];
        s_q[k]   <= s_d[k];
      end
    end
  end

endmodule

// File: tb/tb_adunare_cla_pipe.sv
// Directed self-checking bench for adunare_cla_pipe at WIDTH=16 (latency 4).
module tb_adunare_cla_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = 16'h0;
  logic [15:0] y = 16'h0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  adunare_cla_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] xa, input logic [15:0] ya,
                         input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo);
    x = xa; y = ya; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      if (i < 2) step();
    end
    step();
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_sum"}, 32'(sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(cout), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
    check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] expq[$];
  int n_iss;
  int n_rx;

  initial begin
    // Reset, with in_valid asserted to show it is ignored
    rst = 1'b1; in_valid = 1'b1; x = 16'h1111; y = 16'h2222;
    step(); step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    check_eq("rst_no_transfer", 32'(out_valid), 32'd0);

    run_one("basic_add", 16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0);
    run_one("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_one("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_bin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure: 8 back-to-back adds, out_ready low in cycles 5..7
    n_iss = 0; n_rx = 0; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (n_iss < 8);
      x = 16'(n_iss);
      y = 16'(n_iss) << 8;
      #1;
      check_eq("bp_in_ready", 32'(in_ready), (c >= 5 && c <= 7) ? 32'd0 : 32'd1);
      if (out_valid) begin
        check_eq("bp_queue_nonempty", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          check_eq("bp_sum", 32'(sum), 32'(expq[0]));
          if (out_ready) begin
            void'(expq.pop_front());
            n_rx++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(16'(16'h0101 * n_iss));
        n_iss++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_received", 32'(n_rx), 32'd8);
    check_eq("bp_issued", 32'(n_iss), 32'd8);
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Bubbles: accept on even cycles 0..6 only
    for (int c = 0; c < 12; c++) begin
      in_valid = (c % 2 == 0) && (c <= 6);
      x = 16'(16'h1111 * (c / 2));
      y = 16'h0001;
      step();
      if (c >= 3 && ((c - 3) % 2 == 0) && (c - 3) <= 6) begin
        check_eq("bub_valid", 32'(out_valid), 32'd1);
        check_eq("bub_sum", 32'(sum), 32'(16'(16'h1111 * ((c - 3) / 2)) + 16'h0001));
      end else begin
        check_eq("bub_no_valid", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;

    // Reset with 3 operations in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; x = 16'(16'h0100 + c); y = 16'h0011;
      step();
    end
    rst = 1'b1; in_valid = 1'b1; x = 16'hAAAA;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("mrst_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_sum", 32'(sum), 32'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("mrst_no_stale", 32'(out_valid), 32'd0);
    end
    run_one("post_rst_add", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adunare_cla_pipe.md
# adunare_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands are split into 4-bit lookahead groups. Each group is resolved in its own pipeline stage from the registered group carry of the previous stage, giving one result per cycle at a latency of WIDTH/4 cycles. It is the sequential, wide-word successor to the team's combinational 4-bit lookahead adder and feeds the datapath accumulators and comparators.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
- STAGES (localparam), WIDTH/4, number of 4-bit groups, which equals the number of pipeline stages
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block accepts the operand set this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in for add; borrow-in for sub
- sub  in  1  0 = x+y+cin; 1 = x-y-cin
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result this cycle
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  raw carry out of the MSB; in sub mode, 1 means no borrow
- ovf  out  1  two's-complement overflow

## Operation
- **Operand preprocessing at accept:**
  - yy = sub ? ~y : y
  - c0 = sub ? ~cin : cin
- **Per group k, within stage k:**
  - g = xk & yyk and p = xk ^ yyk (XOR propagate, so the sum is p ^ carry).
  - Internal carries use lookahead form, with no ripple inside the group: c1 = g0|p0c0, c2 = g1|p1g0|p1p0c0, c3 = …, c4 = …
  - Sum bits: s[i] = p[i] ^ c[i].
- **Skew:** group k's operands travel through k delay registers before they are used. Group k's sum bits travel through STAGES-1-k deskew registers, so all sum bits leave together.
- **Carry between stages:** c4 of group k is registered and becomes c0 of group k+1 in the next stage.
- **Flags:** cout = c4 of the top group. ovf = carry into the MSB XOR cout. Both are registered with the final stage.
- **Pipeline stall:** the pipeline moves as a whole.
  - stall = out_valid & ~out_ready.
  - When stall is high, every data and valid register holds its value.
  - in_ready = ~stall (combinational).
- **Bubbles:** a per-stage valid bit travels with the data. A cycle with no accept inserts a bubble. Bubbles collapse only as they reach the output, where out_valid = 0.
- **Data registers** do not need gating by valid; only the valid bits and the held outputs are observable.

## Timing
- **Reset values** (the cycle after rst is sampled high): out_valid=0, sum=0, cout=0, ovf=0, all stage valid bits 0. in_ready=1 once rst is low.
- **Inputs during rst:** while rst is high, in_valid is ignored and no transfer occurs.
- **Reset mid-operation:** every in-flight operation is discarded. No stale result may appear afterwards.
- **Accept:** occurs on a rising edge with in_valid & in_ready & ~rst.
- **Latency:** an operation accepted at edge t produces out_valid=1 with its result after edge t+STAGES-1, i.e. visible during cycle t+STAGES. For WIDTH=4 this is 1 cycle; for WIDTH=16 it is 4 cycles. Each stall cycle adds one cycle.
- **Throughput:** 1 operation per cycle while out_ready=1.
- **Held outputs:** while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid stay stable and no accept occurs.
- **Simultaneous events:** output handshake plus input accept in the same cycle is legal. The pipeline advances and the new operand enters stage 0.
- **Full-width carry propagation** (e.g. 0xFFFF+1) needs no extra cycles; the carry advances one group per stage in step with the operand.
- **Critical path:** one 4-bit lookahead group plus a register. No combinational path spans two groups.

## Test plan
All scenarios use WIDTH=16, latency 4.
1. **Basic add:** add x=0x1234, y=0x0FED, cin=0 -> exactly 4 cycles later sum=0x2221, cout=0, ovf=0.
2. **Full carry ripple and signed overflow:**
   - add x=0xFFFF, y=0x0001 -> sum=0x0000, cout=1, ovf=0.
   - add x=0x7FFF, y=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. **Subtract:**
   - sub x=0x0005, y=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
   - sub x=0x8000, y=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
   - sub x=0x0010, y=0x0001, cin=1 -> sum=0x000E, cout=1.
4. **Backpressure:** stream 8 back-to-back adds (x=i, y=0x0100·i), holding out_ready=0 for 3 cycles mid-stream.
   - in_ready drops exactly during the stall.
   - sum is stable while held.
   - All 8 results emerge in order, none lost or duplicated.
5. **Bubbles:** accept on alternate cycles only -> out_valid toggles 1/0 with the matching results, and no spurious valid appears.
6. **Reset mid-stream:** assert rst for 1 cycle with 3 operations in flight.
   - The next cycle shows out_valid=0, sum=0.
   - No old result appears in the following 6 cycles.
   - A new add issued after reset returns the correct result at latency 4.
